// File: rtl/i2s_master_tx_pkg.sv
// Shared I2S definitions: FSM encoding, default geometry and bit-counter sizing.
package i2s_master_tx_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DEF_AUDIO_DW = 8;
    localparam int DEF_SLOT_W   = 16;
    localparam int DEF_BCNT_W   = $clog2(2 * DEF_SLOT_W);

    function automatic int bcnt_w(input int slot_w);
        return $clog2(2 * slot_w);
    endfunction
endpackage

// File: rtl/i2s_master_tx_if.sv
// Sample-pair valid/ready channel feeding the I2S transmitter.
interface i2s_master_tx_if
    import i2s_master_tx_pkg::*;
#(
    parameter int AUDIO_DW = DEF_AUDIO_DW
);
    logic [AUDIO_DW-1:0] l_data;
    logic [AUDIO_DW-1:0] r_data;
    logic                valid;
    logic                ready;

    modport master (output l_data, output r_data, output valid, input  ready);
    modport slave  (input  l_data, input  r_data, input  valid, output ready);
endinterface

// File: rtl/i2s_sck_div.sv
// SCK generator: divider latched at start, registered sck, combinational strobes
// asserted in the cycle whose rising clk edge toggles sck.
module i2s_sck_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sck_o,
    output logic             rise_o,
    output logic             fall_o
);
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic             tc;

    assign tc     = run_i && (cnt == div_q);
    assign rise_o = tc && !sck_o;
    assign fall_o = tc && sck_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            cnt   <= '0;
            sck_o <= 1'b0;
        end else if (start_i) begin
            div_q <= div_i;
            cnt   <= '0;
            sck_o <= 1'b0;
        end else if (run_i) begin
            if (tc) begin
                cnt   <= '0;
                sck_o <= ~sck_o;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt   <= '0;
            sck_o <= 1'b0;
        end
    end
endmodule

// File: rtl/i2s_master_tx.sv
// Self-clocked Philips-format I2S transmitter with a one-entry holding register
// that repeats the last pair and flags underrun when starved at a frame boundary.
module i2s_master_tx
    import i2s_master_tx_pkg::*;
#(
    parameter int AUDIO_DW = DEF_AUDIO_DW,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int DIV_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    i2s_master_tx_if.slave   smp,
    output logic             sck_o,
    output logic             ws_o,
    output logic             sd_o,
    output logic             underrun_o,
    input  logic             underrun_clr_i
);
    localparam int FW = 2 * SLOT_W;
    localparam int BW = bcnt_w(SLOT_W);
    localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] WS_LO  = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] WS_HI  = BW'(FW - 2);

    logic [0:0]          state;
    logic [BW-1:0]       b;
    logic [BW-1:0]       b_nxt;
    logic [AUDIO_DW-1:0] hold_l;
    logic [AUDIO_DW-1:0] hold_r;
    logic                full;
    logic [FW-1:0]       shreg;
    logic [FW-1:0]       frame_new;
    logic                sck_rise;
    logic                sck_fall;
    logic                boundary;
    logic                stop;
    logic                load;
    logic                xfer;

    i2s_sck_div #(.DIV_W(DIV_W)) u_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(state == ST_IDLE && en_i),
        .run_i  (state == ST_RUN),
        .div_i  (div_i),
        .sck_o  (sck_o),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    a_strobe_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(sck_rise && sck_fall));

    // Slot padding falls out of the '0 default, so SLOT_W == AUDIO_DW needs no special case.
    always_comb begin
        frame_new = '0;
        frame_new[FW-1 -: AUDIO_DW]     = hold_l;
        frame_new[SLOT_W-1 -: AUDIO_DW] = hold_r;
    end

    assign b_nxt     = (b == B_LAST) ? '0 : b + 1'b1;
    assign boundary  = (state == ST_RUN) && sck_fall && (b == B_LAST);
    assign stop      = boundary && !en_i;
    assign load      = boundary && en_i;
    assign smp.ready = !full;
    assign xfer      = smp.valid && !full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            b     <= '0;
            ws_o  <= 1'b0;
            sd_o  <= 1'b0;
            shreg <= '0;
        end else if (state == ST_IDLE) begin
            if (en_i) begin
                state <= ST_RUN;
                b     <= B_LAST;
            end
        end else if (sck_fall) begin
            if (stop) begin
                state <= ST_IDLE;
                ws_o  <= 1'b0;
                sd_o  <= 1'b0;
            end else begin
                b    <= b_nxt;
                ws_o <= (b_nxt >= WS_LO) && (b_nxt <= WS_HI);
                if (load) begin
                    shreg <= frame_new;
                    sd_o  <= frame_new[FW-1];
                end else begin
                    shreg <= shreg << 1;
                    sd_o  <= shreg[FW-2];
                end
            end
        end
    end

    // A capture in the same cycle as a starved boundary leaves the register full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            if (xfer) begin
                full   <= 1'b1;
                hold_l <= smp.l_data;
                hold_r <= smp.r_data;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                underrun_o <= 1'b0;
        else if (load && !full)     underrun_o <= 1'b1;
        else if (underrun_clr_i)    underrun_o <= 1'b0;
    end
endmodule
